car_light_ctrl: RTL and testbench
=================================

CAR_LIGHT_CTRL -- requirements
Module: car_light_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 6000000, meaning clk_in cycles per animation tick (legal range >= 2).
REQ-002 SHALL have port clk_in  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port left_sw  input  1  left turn request, asynchronous to clk_in.
REQ-005 SHALL have port right_sw  input  1  right turn request, asynchronous to clk_in.
REQ-006 SHALL have port hazard_sw  input  1  hazard request, asynchronous to clk_in.
REQ-007 SHALL have port brake_sw  input  1  brake request, asynchronous to clk_in; present only when CAR_LIGHT_BRAKE_EN is defined.
REQ-008 SHALL have port lamp_l  output  3  left lamps, bit0 innermost, 1 = lit, registered.
REQ-009 SHALL have port lamp_r  output  3  right lamps, bit0 innermost, 1 = lit, registered.
REQ-010 SHALL have port mode  output  2  current state: 00 IDLE, 01 LEFT, 10 RIGHT, 11 HAZARD, registered.

Function
REQ-011 SHALL pass every switch input through a 2-flop synchronizer; the switch-to-state latency is therefore 3 clk_in cycles.
REQ-012 SHALL compute the next state from the synchronized switches every cycle, not only on tick: hazard=1 -> HAZARD; hazard=0 with left only -> LEFT; with right only -> RIGHT; with none, or with left and right both set -> IDLE.
REQ-013 SHALL run a tick counter of width $clog2(TICK_DIV) that counts 0..TICK_DIV-1 and wraps, with an internal tick pulse of one cycle when the count equals TICK_DIV-1.
REQ-014 SHALL clear the tick counter to 0 in the cycle the state changes, so that every pattern starts with a full tick period.
REQ-015 SHALL, on entry to LEFT, drive lamp_l=001 and lamp_r=000 in the same cycle mode updates; then on each tick step lamp_l 001->011->111->000->001 (wrapping).
REQ-016 SHALL implement RIGHT as the mirror of LEFT on lamp_r, with lamp_l=000.
REQ-017 SHALL, on entry to HAZARD, drive lamp_l=lamp_r=111; then on each tick toggle both between 111 and 000.
REQ-018 SHALL drive lamp_l=lamp_r=000 in IDLE; the tick counter keeps running in IDLE.
REQ-019 SHALL, when a state change and a tick coincide, apply the state change (entry pattern) and ignore the tick.
REQ-020 SHALL, on LEFT<->RIGHT direct transition, apply entry values for the new state with no intermediate IDLE cycle.

Reset
REQ-021 SHALL, while rst_n=0, asynchronously force mode=00, lamp_l=000, lamp_r=000, tick counter=0, and all synchronizer flops=0.
REQ-022 SHALL, when reset is asserted mid-pattern, discard the pattern; after release the block starts in IDLE and follows REQ-011/REQ-012.

Configuration
REQ-023 SHALL, with CAR_LIGHT_BRAKE_EN defined, synchronize brake_sw per REQ-011; with brake=1: IDLE -> both lamps 111; LEFT -> lamp_r=111; RIGHT -> lamp_l=111; HAZARD is unaffected. The turning side keeps its pattern, and mode and tick phase are not changed by brake.
REQ-024 SHALL, with CAR_LIGHT_BRAKE_EN undefined, omit brake_sw and all brake logic; behaviour is exactly REQ-011..REQ-020.

Verification (TICK_DIV=4)
REQ-025 SHALL cover reset: rst_n=0 with switches toggling -> mode=00, lamps=000/000; after release with all switches at 0 -> lamps stay 000 for 20 cycles.
REQ-026 SHALL cover LEFT: left_sw=1 held -> mode=01 3 cycles later, lamp_l=001, then 011, 111, 000, 001 at 4-cycle intervals; lamp_r=000 throughout.
REQ-027 SHALL cover priority: left_sw=1 and hazard_sw=1 -> mode=11, both lamps 111 then 000 after 4 cycles; dropping hazard_sw -> mode=01, lamp_l=001.
REQ-028 SHALL cover both turn switches: left_sw=right_sw=1 -> mode=00, lamps 000.
REQ-029 SHALL cover a coincident event: right_sw asserted so that the mode change lands on the tick cycle -> lamp_r=001 (entry value), and the next step to 011 follows 4 cycles later.
REQ-030 SHALL cover brake with CAR_LIGHT_BRAKE_EN defined: LEFT active and brake_sw=1 -> lamp_r=111 and the lamp_l sequence is unchanged; in HAZARD, brake_sw=1 -> no change.

Source files
------------

// File: rtl/car_light_ctrl.sv
// rtl/car_light_ctrl.sv - turn/hazard lamp sequencer; optional brake overlay under CAR_LIGHT_BRAKE_EN
module car_light_ctrl #(
  parameter int TICK_DIV = 6000000
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       left_sw,
  input  logic       right_sw,
  input  logic       hazard_sw,
`ifdef CAR_LIGHT_BRAKE_EN
  input  logic       brake_sw,
`endif
  output logic [2:0] lamp_l,
  output logic [2:0] lamp_r,
  output logic [1:0] mode
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

`ifdef CAR_LIGHT_BRAKE_EN
  localparam int NSW = 4;
  logic [NSW-1:0] sw_raw;
  assign sw_raw = {brake_sw, hazard_sw, right_sw, left_sw};
`else
  localparam int NSW = 3;
  logic [NSW-1:0] sw_raw;
  assign sw_raw = {hazard_sw, right_sw, left_sw};
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LEFT   = 2'b01,
    RIGHT  = 2'b10,
    HAZARD = 2'b11
  } state_t;

  logic [NSW-1:0] sw_meta, sw_sync;
  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [2:0]     pat_l, pat_r, pat_l_nxt, pat_r_nxt;
  logic           tick, changed;

  // Chase sequence for one side: 001 -> 011 -> 111 -> 000 -> 001
  function automatic logic [2:0] chase_step(input logic [2:0] p);
    case (p)
      3'b001:  chase_step = 3'b011;
      3'b011:  chase_step = 3'b111;
      3'b111:  chase_step = 3'b000;
      default: chase_step = 3'b001;
    endcase
  endfunction

  // Two-flop synchronizer for every asynchronous switch
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw_raw;
      sw_sync <= sw_meta;
    end
  end

  // State, tick counter and lamp pattern registers
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      pat_l <= 3'b000;
      pat_r <= 3'b000;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pat_l <= pat_l_nxt;
      pat_r <= pat_r_nxt;
    end
  end

  // Next state every cycle; a state change restarts the tick period and wins over a tick
  always_comb begin
    state_nxt = IDLE;
    pat_l_nxt = pat_l;
    pat_r_nxt = pat_r;
    if (sw_sync[2])
      state_nxt = HAZARD;
    else if (sw_sync[0] && !sw_sync[1])
      state_nxt = LEFT;
    else if (sw_sync[1] && !sw_sync[0])
      state_nxt = RIGHT;
    changed = (state_nxt != state);
    tick    = (cnt == TICK_LAST);
    cnt_nxt = (changed || tick) ? '0 : cnt + CW'(1);
    if (changed) begin
      case (state_nxt)
        LEFT:    begin pat_l_nxt = 3'b001; pat_r_nxt = 3'b000; end
        RIGHT:   begin pat_l_nxt = 3'b000; pat_r_nxt = 3'b001; end
        HAZARD:  begin pat_l_nxt = 3'b111; pat_r_nxt = 3'b111; end
        default: begin pat_l_nxt = 3'b000; pat_r_nxt = 3'b000; end
      endcase
    end else if (tick) begin
      case (state)
        LEFT:    pat_l_nxt = chase_step(pat_l);
        RIGHT:   pat_r_nxt = chase_step(pat_r);
        HAZARD:  begin pat_l_nxt = ~pat_l; pat_r_nxt = ~pat_r; end
        default: begin pat_l_nxt = 3'b000; pat_r_nxt = 3'b000; end
      endcase
    end
  end

  assign mode = state;

`ifdef CAR_LIGHT_BRAKE_EN
  logic [2:0] lamp_l_q, lamp_r_q;
  logic       brake;
  assign brake = sw_sync[3];

  // Brake lights every non-turning side on top of the pattern; hazard ignores it
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      lamp_l_q <= 3'b000;
      lamp_r_q <= 3'b000;
    end else begin
      lamp_l_q <= pat_l_nxt | ((brake && (state_nxt == IDLE || state_nxt == RIGHT)) ? 3'b111 : 3'b000);
      lamp_r_q <= pat_r_nxt | ((brake && (state_nxt == IDLE || state_nxt == LEFT))  ? 3'b111 : 3'b000);
    end
  end

  assign lamp_l = lamp_l_q;
  assign lamp_r = lamp_r_q;
`else
  assign lamp_l = pat_l;
  assign lamp_r = pat_r;
`endif

endmodule

// File: tb/tb_car_light_ctrl.sv
// tb/tb_car_light_ctrl.sv - scoreboard bench for car_light_ctrl at TICK_DIV=4
module tb_car_light_ctrl;

  logic       clk_in = 1'b0;
  logic       rst_n = 1'b0;
  logic       left_sw = 1'b0;
  logic       right_sw = 1'b0;
  logic       hazard_sw = 1'b0;
`ifdef CAR_LIGHT_BRAKE_EN
  logic       brake_sw = 1'b0;
`endif
  logic [2:0] lamp_l, lamp_r;
  logic [1:0] mode;

  logic [7:0] exp_q[$];
  logic [7:0] exp_v;
  int         checks = 0;
  int         errors = 0;

  car_light_ctrl #(.TICK_DIV(4)) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .left_sw   (left_sw),
    .right_sw  (right_sw),
    .hazard_sw (hazard_sw),
`ifdef CAR_LIGHT_BRAKE_EN
    .brake_sw  (brake_sw),
`endif
    .lamp_l    (lamp_l),
    .lamp_r    (lamp_r),
    .mode      (mode)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Expected {mode, lamp_l, lamp_r}, pushed n times
  task automatic push(input int n, input logic [1:0] m, input logic [2:0] l, input logic [2:0] r);
    for (int i = 0; i < n; i++) exp_q.push_back({m, l, r});
  endtask

  task automatic drive_edge();
    @(posedge clk_in);
    #1;
  endtask

  task automatic go_idle();
    drive_edge();
    left_sw = 0; right_sw = 0; hazard_sw = 0;
    repeat (6) @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_in); #1;
      left_sw = i[0]; right_sw = i[1]; hazard_sw = ~i[0];
      push(1, 2'b00, 3'b000, 3'b000);
      @(negedge clk_in);
      exp_v = exp_q.pop_front();
      checks++;
      if ({mode, lamp_l, lamp_r} !== exp_v) begin
        errors++;
        $display("FAIL reset_hold: got %b_%b_%b expected %b_%b_%b", mode, lamp_l, lamp_r, exp_v[7:6], exp_v[5:3], exp_v[2:0]);
      end
    end
    left_sw = 0; right_sw = 0; hazard_sw = 0;
    drive_edge();
    rst_n = 1;
    push(20, 2'b00, 3'b000, 3'b000);
    while (exp_q.size() > 0) begin
      @(negedge clk_in);
      exp_v = exp_q.pop_front();
      checks++;
      if ({mode, lamp_l, lamp_r} !== exp_v) begin
        errors++;
        $display("FAIL reset_idle: got %b_%b_%b expected %b_%b_%b", mode, lamp_l, lamp_r, exp_v[7:6], exp_v[5:3], exp_v[2:0]);
      end
    end
  endtask

  task automatic test_left();
    drive_edge();
    left_sw = 1;
    push(3, 2'b00, 3'b000, 3'b000);
    push(4, 2'b01, 3'b001, 3'b000);
    push(4, 2'b01, 3'b011, 3'b000);
    push(4, 2'b01, 3'b111, 3'b000);
    push(4, 2'b01, 3'b000, 3'b000);
    push(1, 2'b01, 3'b001, 3'b000);
    while (exp_q.size() > 0) begin
      @(negedge clk_in);
      exp_v = exp_q.pop_front();
      checks++;
      if ({mode, lamp_l, lamp_r} !== exp_v) begin
        errors++;
        $display("FAIL left_seq: got %b_%b_%b expected %b_%b_%b", mode, lamp_l, lamp_r, exp_v[7:6], exp_v[5:3], exp_v[2:0]);
      end
    end
  endtask

  task automatic test_priority();
    drive_edge();
    left_sw = 1; hazard_sw = 1;
    push(3, 2'b00, 3'b000, 3'b000);
    push(4, 2'b11, 3'b111, 3'b111);
    push(4, 2'b11, 3'b000, 3'b000);
    while (exp_q.size() > 0) begin
      @(negedge clk_in);
      exp_v = exp_q.pop_front();
      checks++;
      if ({mode, lamp_l, lamp_r} !== exp_v) begin
        errors++;
        $display("FAIL hazard_seq: got %b_%b_%b expected %b_%b_%b", mode, lamp_l, lamp_r, exp_v[7:6], exp_v[5:3], exp_v[2:0]);
      end
    end
    drive_edge();
    hazard_sw = 0;
    push(3, 2'b11, 3'b111, 3'b111);
    push(4, 2'b01, 3'b001, 3'b000);
    push(1, 2'b01, 3'b011, 3'b000);
    while (exp_q.size() > 0) begin
      @(negedge clk_in);
      exp_v = exp_q.pop_front();
      checks++;
      if ({mode, lamp_l, lamp_r} !== exp_v) begin
        errors++;
        $display("FAIL hazard_drop: got %b_%b_%b expected %b_%b_%b", mode, lamp_l, lamp_r, exp_v[7:6], exp_v[5:3], exp_v[2:0]);
      end
    end
  endtask

  task automatic test_both_turn();
    drive_edge();
    left_sw = 1; right_sw = 1;
    push(10, 2'b00, 3'b000, 3'b000);
    while (exp_q.size() > 0) begin
      @(negedge clk_in);
      exp_v = exp_q.pop_front();
      checks++;
      if ({mode, lamp_l, lamp_r} !== exp_v) begin
        errors++;
        $display("FAIL both_turn: got %b_%b_%b expected %b_%b_%b", mode, lamp_l, lamp_r, exp_v[7:6], exp_v[5:3], exp_v[2:0]);
      end
    end
    drive_edge();
    right_sw = 0;
    push(3, 2'b00, 3'b000, 3'b000);
    push(1, 2'b01, 3'b001, 3'b000);
    while (exp_q.size() > 0) begin
      @(negedge clk_in);
      exp_v = exp_q.pop_front();
      checks++;
      if ({mode, lamp_l, lamp_r} !== exp_v) begin
        errors++;
        $display("FAIL both_release: got %b_%b_%b expected %b_%b_%b", mode, lamp_l, lamp_r, exp_v[7:6], exp_v[5:3], exp_v[2:0]);
      end
    end
  endtask

  task automatic test_coincident();
    // Enter LEFT, then IDLE to zero the tick counter, then time RIGHT to land on the tick
    drive_edge();
    left_sw = 1;
    push(3, 2'b00, 3'b000, 3'b000);
    push(1, 2'b01, 3'b001, 3'b000);
    while (exp_q.size() > 0) begin
      @(negedge clk_in);
      exp_v = exp_q.pop_front();
      checks++;
      if ({mode, lamp_l, lamp_r} !== exp_v) begin
        errors++;
        $display("FAIL coin_left: got %b_%b_%b expected %b_%b_%b", mode, lamp_l, lamp_r, exp_v[7:6], exp_v[5:3], exp_v[2:0]);
      end
    end
    drive_edge();
    left_sw = 0;
    push(3, 2'b01, 3'b001, 3'b000);
    push(1, 2'b00, 3'b000, 3'b000);
    while (exp_q.size() > 0) begin
      @(negedge clk_in);
      exp_v = exp_q.pop_front();
      checks++;
      if ({mode, lamp_l, lamp_r} !== exp_v) begin
        errors++;
        $display("FAIL coin_idle: got %b_%b_%b expected %b_%b_%b", mode, lamp_l, lamp_r, exp_v[7:6], exp_v[5:3], exp_v[2:0]);
      end
    end
    drive_edge();
    right_sw = 1;
    push(3, 2'b00, 3'b000, 3'b000);
    push(4, 2'b10, 3'b000, 3'b001);
    push(1, 2'b10, 3'b000, 3'b011);
    while (exp_q.size() > 0) begin
      @(negedge clk_in);
      exp_v = exp_q.pop_front();
      checks++;
      if ({mode, lamp_l, lamp_r} !== exp_v) begin
        errors++;
        $display("FAIL coin_right: got %b_%b_%b expected %b_%b_%b", mode, lamp_l, lamp_r, exp_v[7:6], exp_v[5:3], exp_v[2:0]);
      end
    end
    // Direct RIGHT -> LEFT with no IDLE in between
    drive_edge();
    right_sw = 0; left_sw = 1;
    push(3, 2'b10, 3'b000, 3'b011);
    push(1, 2'b01, 3'b001, 3'b000);
    while (exp_q.size() > 0) begin
      @(negedge clk_in);
      exp_v = exp_q.pop_front();
      checks++;
      if ({mode, lamp_l, lamp_r} !== exp_v) begin
        errors++;
        $display("FAIL right_to_left: got %b_%b_%b expected %b_%b_%b", mode, lamp_l, lamp_r, exp_v[7:6], exp_v[5:3], exp_v[2:0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive_edge();
    left_sw = 1;
    push(3, 2'b00, 3'b000, 3'b000);
    push(4, 2'b01, 3'b001, 3'b000);
    push(1, 2'b01, 3'b011, 3'b000);
    while (exp_q.size() > 0) begin
      @(negedge clk_in);
      exp_v = exp_q.pop_front();
      checks++;
      if ({mode, lamp_l, lamp_r} !== exp_v) begin
        errors++;
        $display("FAIL mid_setup: got %b_%b_%b expected %b_%b_%b", mode, lamp_l, lamp_r, exp_v[7:6], exp_v[5:3], exp_v[2:0]);
      end
    end
    // Asynchronous assertion between clock edges
    #2;
    rst_n = 0;
    #1;
    push(1, 2'b00, 3'b000, 3'b000);
    exp_v = exp_q.pop_front();
    checks++;
    if ({mode, lamp_l, lamp_r} !== exp_v) begin
      errors++;
      $display("FAIL mid_async: got %b_%b_%b expected %b_%b_%b", mode, lamp_l, lamp_r, exp_v[7:6], exp_v[5:3], exp_v[2:0]);
    end
    repeat (2) @(posedge clk_in);
    #1;
    rst_n = 1;
    push(3, 2'b00, 3'b000, 3'b000);
    push(4, 2'b01, 3'b001, 3'b000);
    push(1, 2'b01, 3'b011, 3'b000);
    while (exp_q.size() > 0) begin
      @(negedge clk_in);
      exp_v = exp_q.pop_front();
      checks++;
      if ({mode, lamp_l, lamp_r} !== exp_v) begin
        errors++;
        $display("FAIL mid_release: got %b_%b_%b expected %b_%b_%b", mode, lamp_l, lamp_r, exp_v[7:6], exp_v[5:3], exp_v[2:0]);
      end
    end
  endtask

`ifdef CAR_LIGHT_BRAKE_EN
  task automatic test_brake();
    drive_edge();
    brake_sw = 1;
    push(3, 2'b00, 3'b000, 3'b000);
    push(3, 2'b00, 3'b111, 3'b111);
    while (exp_q.size() > 0) begin
      @(negedge clk_in);
      exp_v = exp_q.pop_front();
      checks++;
      if ({mode, lamp_l, lamp_r} !== exp_v) begin
        errors++;
        $display("FAIL brake_idle: got %b_%b_%b expected %b_%b_%b", mode, lamp_l, lamp_r, exp_v[7:6], exp_v[5:3], exp_v[2:0]);
      end
    end
    drive_edge();
    left_sw = 1;
    push(3, 2'b00, 3'b111, 3'b111);
    push(4, 2'b01, 3'b001, 3'b111);
    push(1, 2'b01, 3'b011, 3'b111);
    while (exp_q.size() > 0) begin
      @(negedge clk_in);
      exp_v = exp_q.pop_front();
      checks++;
      if ({mode, lamp_l, lamp_r} !== exp_v) begin
        errors++;
        $display("FAIL brake_left: got %b_%b_%b expected %b_%b_%b", mode, lamp_l, lamp_r, exp_v[7:6], exp_v[5:3], exp_v[2:0]);
      end
    end
    drive_edge();
    hazard_sw = 1;
    push(3, 2'b01, 3'b011, 3'b111);
    push(4, 2'b11, 3'b111, 3'b111);
    push(1, 2'b11, 3'b000, 3'b000);
    while (exp_q.size() > 0) begin
      @(negedge clk_in);
      exp_v = exp_q.pop_front();
      checks++;
      if ({mode, lamp_l, lamp_r} !== exp_v) begin
        errors++;
        $display("FAIL brake_hazard: got %b_%b_%b expected %b_%b_%b", mode, lamp_l, lamp_r, exp_v[7:6], exp_v[5:3], exp_v[2:0]);
      end
    end
    brake_sw = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_left();
    go_idle();
    test_priority();
    go_idle();
    test_both_turn();
    go_idle();
    test_coincident();
    go_idle();
    test_reset_mid();
    go_idle();
`ifdef CAR_LIGHT_BRAKE_EN
    test_brake();
    go_idle();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
